// File: rtl/cvxif_copro_pkg.sv
// Shared constants and types for the CV-X-IF custom-0 coprocessor responder.
// The result entry widths below are the defaults used by the responder parameters.
package cvxif_copro_pkg;

    localparam int unsigned CoproXlen    = 32;
    localparam int unsigned CoproIdWidth = 2;

    localparam logic [6:0] CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_MUL = 3'b001,
        OP_NOP = 3'b010
    } copro_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } copro_state_e;

    typedef struct packed {
        logic [CoproIdWidth-1:0] id;
        logic [CoproXlen-1:0]    data;
        logic [4:0]              rd;
        logic                    we;
        logic                    killed;
    } copro_result_t;

    function automatic logic kill_hit(
        input logic                    kill_valid,
        input logic [CoproIdWidth-1:0] kill_id,
        input logic [CoproIdWidth-1:0] entry_id
    );
        return kill_valid && (kill_id == entry_id);
    endfunction

endpackage

// File: rtl/cvxif_copro_result_fifo.sv
// Synchronous result FIFO with a per-entry killed flag; killed heads are
// discarded one per cycle without ever being presented.
module cvxif_copro_result_fifo
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  copro_result_t                 push_entry,
    input  logic                          pop_ready,
    input  logic                          kill_valid,
    input  logic [CoproIdWidth-1:0]       kill_id,
    output logic                          out_valid,
    output copro_result_t                 out_entry,
    output logic [$clog2(Depth):0]        count
);

    localparam int unsigned AddrW = $clog2(Depth);

    copro_result_t    mem_r [Depth];
    logic [AddrW-1:0] rd_ptr_r;
    logic [AddrW-1:0] wr_ptr_r;
    logic [AddrW:0]   count_r;
    logic             empty_s;
    logic             pop_s;
    copro_result_t    head_s;

    // Head view and pop decision (a killed head pops regardless of ready).
    always_comb begin
        empty_s   = (count_r == {(AddrW+1){1'b0}});
        head_s    = mem_r[rd_ptr_r];
        out_valid = !empty_s && !head_s.killed;
        pop_s     = !empty_s && (head_s.killed || pop_ready);
        out_entry = head_s;
        count     = count_r;
    end

    // Entry storage: writes take priority, otherwise a matching kill marks the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (push && (wr_ptr_r == AddrW'(i))) begin
                    mem_r[i] <= push_entry;
                end else if (kill_hit(kill_valid, kill_id, mem_r[i].id)) begin
                    mem_r[i].killed <= 1'b1;
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {AddrW{1'b0}};
            wr_ptr_r <= {AddrW{1'b0}};
            count_r  <= {(AddrW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AddrW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AddrW'(1);
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + (AddrW+1)'(1);
                2'b01:   count_r <= count_r - (AddrW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: decodes custom-0 ADD/MUL/NOP, executes them (MUL as a
// 32-step shift-add) and returns results in order through a small FIFO.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN         = CoproXlen,
    parameter int unsigned IdWidth      = CoproIdWidth,
    parameter int unsigned ResFifoDepth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o
);

    localparam int unsigned CntW = $clog2(ResFifoDepth) + 1;

    copro_state_e       state_r;
    logic [5:0]         cnt_r;
    logic [XLEN-1:0]    mcand_r;
    logic [XLEN-1:0]    mplier_r;
    logic [XLEN-1:0]    acc_r;
    logic [IdWidth-1:0] mul_id_r;
    logic [4:0]         mul_rd_r;
    logic               pend_valid_r;
    copro_result_t      pend_r;

    logic               accept_s;
    logic               writeback_s;
    logic               is_mul_s;
    logic               is_add_s;
    logic               ready_s;
    logic               hs_s;
    logic               kill_s;
    logic               mul_abort_s;
    logic               mul_done_s;
    logic [XLEN-1:0]    acc_next_s;
    logic               push_s;
    copro_result_t      push_entry_s;
    logic [CntW-1:0]    fifo_count_s;
    logic [CntW:0]      occupancy_s;
    logic               fifo_valid_s;
    copro_result_t      fifo_head_s;
    logic               unused_s;

    // Instruction decode; only custom-0 with funct7 == 0 and a known funct3 is taken.
    always_comb begin
        accept_s    = 1'b0;
        writeback_s = 1'b0;
        is_mul_s    = 1'b0;
        is_add_s    = 1'b0;
        if ((issue_instr_i[6:0] == CUSTOM0) && (issue_instr_i[31:25] == 7'd0)) begin
            case (issue_instr_i[14:12])
                OP_ADD: begin
                    accept_s    = 1'b1;
                    writeback_s = 1'b1;
                    is_add_s    = 1'b1;
                end
                OP_MUL: begin
                    accept_s    = 1'b1;
                    writeback_s = 1'b1;
                    is_mul_s    = 1'b1;
                end
                OP_NOP: begin
                    accept_s    = 1'b1;
                end
                default: begin
                    accept_s    = 1'b0;
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Handshake, kill qualification and multiplier step.
    always_comb begin
        occupancy_s = {1'b0, fifo_count_s} + {{CntW{1'b0}}, pend_valid_r};
        ready_s     = !rst_i && (state_r == IDLE) && (occupancy_s < (CntW+1)'(ResFifoDepth));
        hs_s        = issue_valid_i && ready_s;
        kill_s      = commit_valid_i && commit_kill_i;
        mul_abort_s = (state_r == MUL) && kill_hit(kill_s, commit_id_i, mul_id_r);
        mul_done_s  = (state_r == MUL) && (cnt_r == 6'd31) && !mul_abort_s;
        acc_next_s  = acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});
    end

    // FIFO push source: a finishing MUL and a pending ADD/NOP never coincide.
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '0;
        if (mul_done_s) begin
            push_s              = 1'b1;
            push_entry_s.id     = mul_id_r;
            push_entry_s.data   = acc_next_s;
            push_entry_s.rd     = mul_rd_r;
            push_entry_s.we     = 1'b1;
            push_entry_s.killed = 1'b0;
        end else if (pend_valid_r) begin
            push_s              = 1'b1;
            push_entry_s        = pend_r;
            push_entry_s.killed = kill_hit(kill_s, commit_id_i, pend_r.id);
        end else begin
            push_s = 1'b0;
        end
    end

    // Control FSM plus the pending single-cycle result and MUL datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            cnt_r        <= 6'd0;
            mcand_r      <= {XLEN{1'b0}};
            mplier_r     <= {XLEN{1'b0}};
            acc_r        <= {XLEN{1'b0}};
            mul_id_r     <= {IdWidth{1'b0}};
            mul_rd_r     <= 5'd0;
            pend_valid_r <= 1'b0;
            pend_r       <= '0;
        end else begin
            pend_valid_r <= hs_s && accept_s && !is_mul_s;
            if (hs_s && accept_s && !is_mul_s) begin
                pend_r.id     <= issue_id_i;
                pend_r.data   <= is_add_s ? (issue_rs1_i + issue_rs2_i) : {XLEN{1'b0}};
                pend_r.rd     <= writeback_s ? issue_instr_i[11:7] : 5'd0;
                pend_r.we     <= writeback_s;
                pend_r.killed <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (hs_s && accept_s && is_mul_s) begin
                        state_r  <= MUL;
                        cnt_r    <= 6'd0;
                        mcand_r  <= issue_rs1_i;
                        mplier_r <= issue_rs2_i;
                        acc_r    <= {XLEN{1'b0}};
                        mul_id_r <= issue_id_i;
                        mul_rd_r <= issue_instr_i[11:7];
                    end
                end
                MUL: begin
                    if (mul_abort_s || (cnt_r == 6'd31)) begin
                        state_r <= IDLE;
                    end else begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                        cnt_r    <= cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    cvxif_copro_result_fifo #(
        .Depth (ResFifoDepth)
    ) u_result_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop_ready  (result_ready_i),
        .kill_valid (kill_s),
        .kill_id    (commit_id_i),
        .out_valid  (fifo_valid_s),
        .out_entry  (fifo_head_s),
        .count      (fifo_count_s)
    );

    // Output drive; result fields read as zero whenever no result is offered.
    always_comb begin
        issue_ready_o     = ready_s;
        issue_accept_o    = issue_valid_i && accept_s;
        issue_writeback_o = issue_valid_i && writeback_s;
        result_valid_o    = fifo_valid_s;
        if (fifo_valid_s) begin
            result_id_o   = fifo_head_s.id;
            result_data_o = fifo_head_s.data;
            result_rd_o   = fifo_head_s.rd;
            result_we_o   = fifo_head_s.we;
        end else begin
            result_id_o   = {IdWidth{1'b0}};
            result_data_o = {XLEN{1'b0}};
            result_rd_o   = 5'd0;
            result_we_o   = 1'b0;
        end
    end

    assign unused_s = ^{issue_instr_i[24:15], fifo_head_s.killed};

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Scoreboard bench for cvxif_copro_responder: directed scenarios followed by
// randomized traffic checked against an arithmetic reference model.
module tb_cvxif_copro_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [1:0]  issue_id_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [1:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [1:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ready_mode = 2;   // 0 random, 1 hold low, 2 hold high

    cvxif_copro_responder dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: what the instruction should produce, from the ISA rules alone.
    function automatic void model(input logic [31:0] instr, input logic [31:0] a,
                                  input logic [31:0] b, output bit acc, output exp_t e);
        logic [63:0] prod;
        acc  = 1'b0;
        e    = '0;
        prod = {32'h0, a} * {32'h0, b};
        if (instr[6:0] == 7'b0001011 && instr[31:25] == 7'd0) begin
            case (instr[14:12])
                3'd0: begin acc = 1'b1; e.data = a + b;       e.rd = instr[11:7]; e.we = 1'b1; end
                3'd1: begin acc = 1'b1; e.data = prod[31:0];  e.rd = instr[11:7]; e.we = 1'b1; end
                3'd2: begin acc = 1'b1; end
                default: acc = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        logic [9:0] rs;
        rs = 10'($urandom);
        return {f7, rs, f3, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       result_ready_i = 1'($urandom_range(0, 1));
            1:       result_ready_i = 1'b0;
            default: result_ready_i = 1'b1;
        endcase
    endtask

    task automatic issue(input logic [31:0] instr, input logic [1:0] id,
                         input logic [31:0] a, input logic [31:0] b);
        bit   acc;
        bit   done;
        exp_t e;
        done = 1'b0;
        model(instr, a, b, acc, e);
        e.id = id;
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_id_i    = id;
        issue_rs1_i   = a;
        issue_rs2_i   = b;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (issue_ready_o) begin
                check("issue_accept", 64'(issue_accept_o), 64'(acc));
                check("issue_writeback", 64'(issue_writeback_o), 64'(e.we));
                if (acc) sb.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        issue_valid_i = 1'b0;
        if (!done) check("issue_timeout", 64'(done), 64'd1);
    endtask

    task automatic commit(input logic [1:0] id, input logic kill);
        exp_t keep[$];
        commit_valid_i = 1'b1;
        commit_kill_i  = kill;
        commit_id_i    = id;
        result_ready_i = 1'b0;
        if (kill) begin
            foreach (sb[i]) if (sb[i].id != id) keep.push_back(sb[i]);
            sb = keep;
        end
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    // Monitor: every result the core takes must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_i && result_valid_o && result_ready_i) begin
            check("result_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'({result_id_o, result_data_o, result_rd_o, result_we_o}), 64'(e));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        bit seen;
        rst_i = 1'b1;
        issue_valid_i = 1'b0;
        issue_instr_i = 32'd0;
        issue_id_i = 2'd0;
        issue_rs1_i = 32'd0;
        issue_rs2_i = 32'd0;
        commit_valid_i = 1'b0;
        commit_id_i = 2'd0;
        commit_kill_i = 1'b0;
        result_ready_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_result_valid", 64'(result_valid_o), 64'd0);
        check("reset_result_data", 64'(result_data_o), 64'd0);
        check("reset_accept", 64'(issue_accept_o), 64'd0);
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(issue_ready_o), 64'd1);
        tick();

        // ADD id1: 5 + 7 -> rd3, visible two cycles after the handshake
        issue(mk(7'd0, 3'd0, 5'd3, 7'b0001011), 2'd1, 32'd5, 32'd7);
        @(negedge clk);
        check("add_latency_c1", 64'(result_valid_o), 64'd0);
        tick();
        @(negedge clk);
        check("add_latency_c2", 64'(result_valid_o), 64'd1);
        tick();

        // MUL id2: busy for 32 cycles
        issue(mk(7'd0, 3'd1, 5'd5, 7'b0001011), 2'd2, 32'hFFFF_FFFF, 32'd3);
        low = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (issue_ready_o) seen = 1'b1;
            else low++;
            tick();
        end
        check("mul_busy_cycles", 64'(low), 64'd32);
        repeat (3) tick();

        // Standard RV ADD is rejected and yields nothing
        issue(32'h0000_0033, 2'd3, 32'd1, 32'd1);
        @(negedge clk);
        check("reject_ready", 64'(issue_ready_o), 64'd1);
        repeat (4) tick();

        // Fill the FIFO with result_ready low, then drain in order
        ready_mode = 1;
        tick();
        issue(mk(7'd0, 3'd0, 5'd1, 7'b0001011), 2'd0, 32'd1, 32'd2);
        issue(mk(7'd0, 3'd0, 5'd2, 7'b0001011), 2'd1, 32'd3, 32'd4);
        @(negedge clk);
        check("full_not_ready_a", 64'(issue_ready_o), 64'd0);
        tick();
        @(negedge clk);
        check("full_not_ready_b", 64'(issue_ready_o), 64'd0);
        ready_mode = 2;
        repeat (4) tick();
        @(negedge clk);
        check("drained_ready", 64'(issue_ready_o), 64'd1);
        tick();

        // MUL id0 killed mid-flight
        issue(mk(7'd0, 3'd1, 5'd7, 7'b0001011), 2'd0, 32'd7, 32'd9);
        repeat (9) tick();
        commit(2'd0, 1'b1);
        @(negedge clk);
        check("ready_after_kill", 64'(issue_ready_o), 64'd1);
        repeat (40) tick();

        // Two buffered NOPs, kill id1, only id2 comes out
        ready_mode = 1;
        tick();
        issue(mk(7'd0, 3'd2, 5'd9, 7'b0001011), 2'd1, 32'd11, 32'd12);
        issue(mk(7'd0, 3'd2, 5'd10, 7'b0001011), 2'd2, 32'd13, 32'd14);
        repeat (2) tick();
        commit(2'd1, 1'b1);
        ready_mode = 2;
        repeat (5) tick();
        check("nop_kill_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a MUL loses it
        issue(mk(7'd0, 3'd1, 5'd4, 7'b0001011), 2'd3, 32'd6, 32'd6);
        repeat (5) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midmul_reset_ready", 64'(issue_ready_o), 64'd1);
        check("midmul_reset_valid", 64'(result_valid_o), 64'd0);
        repeat (40) tick();

        // Randomized traffic
        ready_mode = 0;
        for (int it = 0; it < 150; it++) begin
            int unsigned sel;
            logic [1:0]  id;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            sel = $urandom_range(0, 9);
            id  = 2'($urandom);
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom);
            case (sel)
                0, 1, 2: issue(mk(7'd0, 3'd0, rd, 7'b0001011), id, a, b);
                3, 4:    issue(mk(7'd0, 3'd1, rd, 7'b0001011), id, a, b);
                5, 6:    issue(mk(7'd0, 3'd2, rd, 7'b0001011), id, a, b);
                7: begin
                    case ($urandom_range(0, 2))
                        0:       issue(mk(7'd0, 3'd0, rd, 7'b0110011), id, a, b);
                        1:       issue(mk(7'd1 | 7'($urandom), 3'd0, rd, 7'b0001011), id, a, b);
                        default: issue(mk(7'd0, 3'(3 + $urandom_range(0, 4)), rd, 7'b0001011), id, a, b);
                    endcase
                end
                8:       commit(id, 1'b1);
                default: commit(id, 1'b0);
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        // Drain everything still outstanding
        ready_mode = 2;
        for (int n = 0; n < 300 && (sb.size() != 0 || !issue_ready_o); n++) tick();
        repeat (5) tick();
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cvxif_copro_responder.md
Name: cvxif_copro_responder

Overview:
- Coprocessor-side (responder) end of the CV-X-IF interface. The embedded CVA6 core acts as the issuer.
- Accepts custom-0 instructions offloaded by the core, executes them (1-cycle add, 32-cycle iterative multiply, no-op), and returns results through a small result FIFO.
- Honours commit-kill from the core for instructions still in flight.
- Sits beside the core in the embedded SoC, connected to the core's cvxif request/response ports.

Parameters:
- XLEN, 32, operand/result width.
- IdWidth, 2, instruction id width (covers 4 scoreboard entries).
- ResFifoDepth, 2, result FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- issue_valid_i  in  1  core offers instruction
- issue_ready_o  out  1  responder can take an issue this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_rs1_i  in  XLEN  rs1 value
- issue_rs2_i  in  XLEN  rs2 value
- issue_accept_o  out  1  instruction is a coprocessor instruction (valid during the issue handshake)
- issue_writeback_o  out  1  accepted instruction writes rd
- commit_valid_i  in  1  commit/kill message valid
- commit_id_i  in  IdWidth  id being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit (no action)
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  IdWidth  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable for rd

Behaviour:
- Reset (rst_i=1 at a clock edge): FSM to IDLE, FIFO empty, all outputs 0 except issue_ready_o=1 after the reset cycle.
- Decode (combinational on issue_instr_i):
  - Accepted when opcode[6:0]=7'b0001011 and funct7=0.
  - funct3=000 ADD: rd=rs1+rs2 mod 2^32.
  - funct3=001 MUL: low 32 bits of rs1*rs2.
  - funct3=010 NOP: we=0, rd=0.
  - Any other funct3 or opcode: accept=0, writeback=0.
- issue_accept_o and issue_writeback_o are combinational and valid whenever issue_valid_i=1.
- issue_ready_o = (state==IDLE) && (fifo_count + pending < ResFifoDepth). Pending counts an ADD/NOP registered this cycle.
- An issue handshake occurs on issue_valid_i && issue_ready_o. Rejected instructions complete the handshake but produce no result.
- ADD/NOP: result enters the FIFO on the cycle after the handshake. result_valid_o is high at earliest 2 cycles after the handshake (FIFO registered).
- MUL: FSM goes IDLE->MUL. It runs a shift-add over 32 cycles using a 6-bit counter 0..31. On the cycle the counter reaches 31 the result is pushed and the FSM returns to IDLE. Total latency is 33 cycles to the FIFO push.
- FIFO: result_valid_o = !empty && !head_killed. A pop occurs on result_valid_o && result_ready_i.
- Killed head entries are popped silently, one per cycle, with no output.
- Kill handling (commit_valid_i && commit_kill_i):
  - A MUL in flight with matching id aborts; FSM goes to IDLE and no push occurs.
  - FIFO entries with matching id are marked killed.
  - Kill is ignored for an id issued in the same cycle.
  - Commit with kill=0 has no effect.
- Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Issue is never offered while full, so no overflow case exists.
- Reset mid-MUL: the operation is lost, FIFO is cleared, and no result is emitted.

Decomposition:
- Shared package cvxif_copro_pkg holds:
  - opcode constant CUSTOM0=7'b0001011
  - funct3 enum copro_op_e {ADD, MUL, NOP}
  - result struct {id, data, rd, we, killed}
  - FSM enum {IDLE, MUL}
- One sub-module: cvxif_copro_result_fifo. It is a parameterised sync FIFO with a per-entry killed flag and an id-match kill input.

Test Plan:
- Reset, then ADD id=1, rs1=5, rs2=7, rd=3 -> accept=1, writeback=1; two cycles later result_valid=1, data=12, rd=3, id=1, we=1.
- MUL id=2, rs1=0xFFFF_FFFF, rs2=3 -> issue_ready_o low for 32 cycles; result data=0xFFFF_FFFD at cycle 34.
- Instruction 0x0000_0033 (standard ADD) -> accept=0, issue_ready stays 1, no result ever.
- Hold result_ready_i=0 and issue two ADDs -> FIFO full and issue_ready_o=0; release ready -> results drain in order, ready returns high.
- MUL id=0, then kill id=0 at cycle 10 -> no result; issue_ready_o=1 the next cycle.
- Two NOPs (id 1, 2) buffered with ready=0, kill id=1, then ready=1 -> only id=2 returned, we=0.
